// File: rtl/instr_decode_issue.sv
// Instruction decode/issue front end: accepts one word, decodes ALU fields, checks the
// condition against NZCV, issues to the ALU and waits for completion (or timeout).
module instr_decode_issue #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [31:0]      instr,
    input  logic [3:0]       flags,
    output logic             issue_valid,
    input  logic             issue_ready,
    input  logic             alu_done,
    output logic [3:0]       opcode,
    output logic [3:0]       cond,
    output logic             s,
    output logic [3:0]       rd,
    output logic [3:0]       rn,
    output logic [3:0]       rm,
    output logic [2:0]       sr_cont,
    output logic [4:0]       sr_bit,
    output logic [15:0]      imm,
    output logic             skip,
    output logic             illegal,
    output logic             timeout,
    output logic [CNT_W-1:0] retire_cnt
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [3:0] OP_MOVI = 4'b0110;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EVAL  = 2'd1,
        ISSUE = 2'd2,
        WAIT  = 2'd3
    } state_t;

    state_t        state_reg;
    state_t        state_next;
    logic [TW-1:0] wait_cnt_reg;
    logic          skip_next;
    logic          illegal_next;
    logic          timeout_set;
    logic          retire_inc;
    logic          accept;
    logic          opcode_legal;
    logic          cond_pass;
    logic          is_movi;

    logic          flag_n, flag_z, flag_c, flag_v;

    assign instr_ready = (state_reg == IDLE);
    assign issue_valid = (state_reg == ISSUE);
    assign accept      = instr_valid && instr_ready;
    assign is_movi     = (instr[27:24] == OP_MOVI);

    assign flag_n = flags[3];
    assign flag_z = flags[2];
    assign flag_c = flags[1];
    assign flag_v = flags[0];

    always_comb begin
        case (opcode)
            4'b1011, 4'b1101, 4'b1110: opcode_legal = 1'b1;
            default:                   opcode_legal = (opcode[3] == 1'b0);
        endcase
    end

    // Evaluated against the flags present during EVAL, i.e. after the prior op retired.
    always_comb begin
        case (cond)
            4'h0:    cond_pass = flag_z;
            4'h1:    cond_pass = !flag_z;
            4'h2:    cond_pass = flag_c;
            4'h3:    cond_pass = !flag_c;
            4'h4:    cond_pass = flag_n;
            4'h5:    cond_pass = !flag_n;
            4'h6:    cond_pass = flag_v;
            4'h7:    cond_pass = !flag_v;
            4'h8:    cond_pass = flag_c && !flag_z;
            4'h9:    cond_pass = !flag_c || flag_z;
            4'hA:    cond_pass = (flag_n == flag_v);
            4'hB:    cond_pass = (flag_n != flag_v);
            4'hC:    cond_pass = !flag_z && (flag_n == flag_v);
            4'hD:    cond_pass = flag_z || (flag_n != flag_v);
            4'hE:    cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    always_comb begin
        state_next   = state_reg;
        skip_next    = 1'b0;
        illegal_next = 1'b0;
        timeout_set  = 1'b0;
        retire_inc   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (instr_valid) state_next = EVAL;
            end
            EVAL: begin
                if (!opcode_legal) begin
                    illegal_next = 1'b1;
                    state_next   = IDLE;
                end else if (!cond_pass) begin
                    skip_next  = 1'b1;
                    state_next = IDLE;
                end else begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (issue_ready) state_next = WAIT;
            end
            WAIT: begin
                if (alu_done) begin
                    retire_inc = 1'b1;
                    state_next = IDLE;
                end else if (wait_cnt_reg == TW'(TIMEOUT_CYCLES - 1)) begin
                    timeout_set = 1'b1;
                    state_next  = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            wait_cnt_reg <= '0;
            skip         <= 1'b0;
            illegal      <= 1'b0;
            timeout      <= 1'b0;
            retire_cnt   <= '0;
        end else begin
            state_reg <= state_next;
            skip      <= skip_next;
            illegal   <= illegal_next;
            if (timeout_set) timeout <= 1'b1;
            if (retire_inc)  retire_cnt <= retire_cnt + CNT_W'(1);
            if (state_reg == ISSUE) begin
                wait_cnt_reg <= '0;
            end else if (state_reg == WAIT) begin
                wait_cnt_reg <= wait_cnt_reg + TW'(1);
            end
        end
    end

    // Field registers load only on accept and otherwise hold their last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opcode  <= '0;
            cond    <= '0;
            s       <= 1'b0;
            rd      <= '0;
            rn      <= '0;
            rm      <= '0;
            sr_cont <= '0;
            sr_bit  <= '0;
            imm     <= '0;
        end else if (accept) begin
            opcode <= instr[27:24];
            cond   <= instr[31:28];
            if (is_movi) begin
                s       <= 1'b0;
                rd      <= instr[23:20];
                rn      <= '0;
                rm      <= '0;
                sr_cont <= '0;
                sr_bit  <= '0;
                imm     <= instr[19:4];
            end else begin
                s       <= instr[23];
                rd      <= instr[22:19];
                rn      <= instr[18:15];
                rm      <= instr[14:11];
                sr_cont <= instr[10:8];
                sr_bit  <= instr[7:3];
                imm     <= '0;
            end
        end
    end

endmodule

// File: tb/tb_instr_decode_issue.sv
// Self-checking bench for instr_decode_issue: directed cases followed by randomized
// transactions checked against a behavioural model of decode, condition and timing.
module tb_instr_decode_issue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [31:0] instr = '0;
    logic [3:0]  flags = '0;
    logic        issue_valid;
    logic        issue_ready = 1'b0;
    logic        alu_done = 1'b0;
    logic [3:0]  opcode, cond, rd, rn, rm;
    logic        s, skip, illegal, timeout;
    logic [2:0]  sr_cont;
    logic [4:0]  sr_bit;
    logic [15:0] imm;
    logic [15:0] retire_cnt;

    int          n_vec = 0;
    int          n_err = 0;
    int          retire_exp = 0;
    logic        timeout_exp = 1'b0;

    always #5 clk = ~clk;

    instr_decode_issue #(.TIMEOUT_CYCLES(64), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .flags(flags), .issue_valid(issue_valid), .issue_ready(issue_ready),
        .alu_done(alu_done), .opcode(opcode), .cond(cond), .s(s), .rd(rd), .rn(rn), .rm(rm),
        .sr_cont(sr_cont), .sr_bit(sr_bit), .imm(imm), .skip(skip), .illegal(illegal),
        .timeout(timeout), .retire_cnt(retire_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Legal opcode set as a bit mask: 0-7, 11, 13, 14.
    function automatic bit model_legal(input int op);
        int mask = 'h68FF;
        return ((mask >> op) & 1) == 1;
    endfunction

    // Conditions come in true/inverted pairs; AL/NV handled separately.
    function automatic bit model_cond(input int c, input int fl);
        int n = (fl >> 3) & 1;
        int z = (fl >> 2) & 1;
        int cy = (fl >> 1) & 1;
        int v = fl & 1;
        int base;
        if (c == 14) return 1'b1;
        if (c == 15) return 1'b0;
        case (c / 2)
            0: base = z;
            1: base = cy;
            2: base = n;
            3: base = v;
            4: base = (cy == 1 && z == 0) ? 1 : 0;
            5: base = (n == v) ? 1 : 0;
            default: base = (z == 0 && n == v) ? 1 : 0;
        endcase
        return (c % 2 == 0) ? (base == 1) : (base == 0);
    endfunction

    // Packed as {opcode, cond, s, rd, rn, rm, sr_cont, sr_bit, imm}.
    function automatic logic [63:0] model_fields(input logic [31:0] w);
        int op = int'(w >> 24) & 15;
        int cd = int'(w >> 28) & 15;
        logic [63:0] r;
        if (op == 6)
            r = {19'd0, 4'(op), 4'(cd), 1'b0, 4'((w >> 20) & 15), 8'd0, 8'd0,
                 16'((w >> 4) & 32'hFFFF)};
        else
            r = {19'd0, 4'(op), 4'(cd), 1'((w >> 23) & 1), 4'((w >> 19) & 15),
                 4'((w >> 15) & 15), 4'((w >> 11) & 15), 3'((w >> 8) & 7),
                 5'((w >> 3) & 31), 16'd0};
        return r;
    endfunction

    function automatic logic [63:0] dut_fields();
        return {19'd0, opcode, cond, s, rd, rn, rm, sr_cont, sr_bit, imm};
    endfunction

    // mode 0: alu_done after done_wait cycles; 1: never done (timeout); 2: reset in WAIT
    task automatic txn(input logic [31:0] word, input logic [3:0] fl, input int issue_wait,
                       input int done_wait, input bit done_in_issue, input int mode);
        logic [63:0] ef = model_fields(word);
        int op = int'(word >> 24) & 15;
        int cd = int'(word >> 28) & 15;
        @(negedge clk);
        chk("idle_ready", 64'(instr_ready), 64'd1);
        chk("idle_pulses", {62'd0, skip, illegal}, 64'd0);
        chk("idle_issue_valid", 64'(issue_valid), 64'd0);
        chk("timeout_hold", 64'(timeout), 64'(timeout_exp));
        chk("retire_hold", 64'(retire_cnt), 64'(retire_exp & 'hFFFF));
        instr_valid = 1'b1;
        instr = word;
        flags = fl;
        @(negedge clk);
        instr_valid = 1'b0;
        instr = $urandom;
        chk("eval_ready", 64'(instr_ready), 64'd0);
        chk("eval_issue_valid", 64'(issue_valid), 64'd0);
        chk("fields", dut_fields(), ef);
        @(negedge clk);
        if (!model_legal(op)) begin
            chk("illegal_pulse", {62'd0, skip, illegal}, 64'd1);
            chk("illegal_ready", {62'd0, instr_ready, issue_valid}, 64'd2);
            $display("txn %08h flags=%h -> illegal", word, fl);
            return;
        end
        if (!model_cond(cd, int'(fl))) begin
            chk("skip_pulse", {62'd0, skip, illegal}, 64'd2);
            chk("skip_ready", {62'd0, instr_ready, issue_valid}, 64'd2);
            $display("txn %08h flags=%h -> skip", word, fl);
            return;
        end
        chk("issue_valid_up", {62'd0, instr_ready, issue_valid}, 64'd1);
        for (int i = 0; i < issue_wait; i++) begin
            alu_done = done_in_issue && (i == 0);
            @(negedge clk);
            alu_done = 1'b0;
            chk("issue_hold", 64'(issue_valid), 64'd1);
            chk("issue_fields", dut_fields(), ef);
            chk("issue_no_retire", 64'(retire_cnt), 64'(retire_exp & 'hFFFF));
        end
        issue_ready = 1'b1;
        @(negedge clk);
        issue_ready = 1'b0;
        chk("wait_entry", {62'd0, instr_ready, issue_valid}, 64'd0);
        if (mode == 1) begin
            for (int i = 0; i < 63; i++) begin
                @(negedge clk);
                chk("wait_busy", {62'd0, instr_ready, timeout}, 64'(timeout_exp));
            end
            @(negedge clk);
            timeout_exp = 1'b1;
            chk("timeout_idle", {62'd0, instr_ready, timeout}, 64'd3);
            chk("timeout_no_retire", 64'(retire_cnt), 64'(retire_exp & 'hFFFF));
            $display("txn %08h flags=%h -> timeout", word, fl);
        end else if (mode == 2) begin
            #2 rst_n = 1'b0;
            #1;
            retire_exp = 0;
            timeout_exp = 1'b0;
            chk("rst_ready", {62'd0, instr_ready, issue_valid}, 64'd2);
            chk("rst_pulses", {61'd0, skip, illegal, timeout}, 64'd0);
            chk("rst_retire", 64'(retire_cnt), 64'd0);
            chk("rst_fields", dut_fields(), 64'd0);
            @(negedge clk);
            rst_n = 1'b1;
            $display("txn %08h flags=%h -> reset in WAIT", word, fl);
        end else begin
            for (int i = 0; i < done_wait; i++) begin
                @(negedge clk);
                chk("wait_busy", 64'(instr_ready), 64'd0);
            end
            alu_done = 1'b1;
            @(negedge clk);
            alu_done = 1'b0;
            retire_exp++;
            chk("retire_idle", 64'(instr_ready), 64'd1);
            chk("retire_cnt", 64'(retire_cnt), 64'(retire_exp & 'hFFFF));
            chk("fields_after", dut_fields(), ef);
            $display("txn %08h flags=%h -> retired, retire_cnt=%0d", word, fl, retire_cnt);
        end
    endtask

    initial begin
        logic [31:0] w;
        #3;
        chk("reset_ready", {62'd0, instr_ready, issue_valid}, 64'd2);
        chk("reset_pulses", {61'd0, skip, illegal, timeout}, 64'd0);
        chk("reset_retire", 64'(retire_cnt), 64'd0);
        chk("reset_fields", dut_fields(), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        txn(32'hE08A2A28, 4'h0, 0, 0, 1'b0, 0);   // ADD AL, s=1
        txn(32'hE6312340, 4'h0, 1, 2, 1'b0, 0);   // MOVI rd=3 imm=0x1234
        txn(32'h008A2A28, 4'h0, 0, 0, 1'b0, 0);   // EQ with Z=0 -> skip
        txn(32'hF9000000, 4'h0, 0, 0, 1'b0, 0);   // opcode 1001, NV -> illegal
        txn(32'hE9000000, 4'hF, 0, 0, 1'b0, 0);   // illegal even when cond passes
        txn(32'hE3000000, 4'h0, 2, 0, 1'b1, 1);   // never done -> timeout
        txn(32'hEB123456, 4'h4, 0, 1, 1'b0, 0);   // accepted after timeout
        txn(32'hE0ABCDEF, 4'h0, 0, 3, 1'b0, 2);   // reset during WAIT
        txn(32'hD4000000, 4'h4, 0, 0, 1'b0, 0);   // LE with Z=1

        for (int k = 0; k < 40; k++) begin
            w = $urandom;
            if ($urandom_range(3) == 0) w[27:24] = 4'h6;
            if ($urandom_range(2) == 0) w[31:28] = 4'hE;
            txn(w, 4'($urandom_range(15)), $urandom_range(3), $urandom_range(5),
                1'($urandom_range(1)), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
